// File: rtl/risc_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, owner
// encoding and the arbitration FSM state type.
package risc_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_LDR  = 2'b10;

    typedef enum logic [0:0] {
        CORE_PRIO = 1'b0,
        LDR_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Loader starvation counter: counts consecutive blocked loader cycles and
// flags the edge at which the loader must be forced onto the memory.
module arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ldr_req,
    input  logic ldr_gnt,
    output logic force_next
);

    logic       blocked;
    logic [3:0] wait_cnt;
    logic [4:0] cnt_inc;

    assign blocked    = ldr_req && !ldr_gnt;
    assign cnt_inc    = {1'b0, wait_cnt} + 5'd1;
    assign force_next = blocked && (cnt_inc >= 5'(MAX_WAIT));

    // Saturates at 15 so a misconfigured MAX_WAIT can never wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (!blocked) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= cnt_inc[3:0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: core has default
// priority, the loader is forced for one access after MAX_WAIT blocked cycles.
module dmem_arbiter
    import risc_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_owner
);

    arb_state_e    state, state_nxt;
    logic          force_next;
    logic [1:0]    rsp_owner_p1;
    logic [1:0]    rsp_owner_p0;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] ldr_rdata_q;

    // Stage p0: same-cycle grant and memory mux
    always_comb begin
        core_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (state == LDR_FORCE) begin
            ldr_gnt  = ldr_req;
            core_gnt = core_req && !ldr_req;
        end else begin
            core_gnt = core_req;
            ldr_gnt  = ldr_req && !core_req;
        end
    end

    assign core_stall = core_req && !core_gnt;
    assign mem_en     = core_gnt | ldr_gnt;

    always_comb begin
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dbg_owner    = OWN_NONE;
        rsp_owner_p0 = OWN_NONE;
        if (core_gnt) begin
            mem_we       = core_we;
            mem_addr     = core_addr;
            mem_wdata    = core_wdata;
            dbg_owner    = OWN_CORE;
            rsp_owner_p0 = core_we ? OWN_NONE : OWN_CORE;
        end else if (ldr_gnt) begin
            mem_we       = ldr_we;
            mem_addr     = ldr_addr;
            mem_wdata    = ldr_wdata;
            dbg_owner    = OWN_LDR;
            rsp_owner_p0 = ldr_we ? OWN_NONE : OWN_LDR;
        end
    end

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .ldr_req    (ldr_req),
        .ldr_gnt    (ldr_gnt),
        .force_next (force_next)
    );

    // The forced state lasts exactly one loader access (or ends if it gives up).
    always_comb begin
        state_nxt = state;
        case (state)
            CORE_PRIO: if (force_next) state_nxt = LDR_FORCE;
            LDR_FORCE: if (ldr_gnt || !ldr_req) state_nxt = CORE_PRIO;
            default:   state_nxt = CORE_PRIO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CORE_PRIO;
            rsp_owner_p1 <= OWN_NONE;
        end else begin
            state        <= state_nxt;
            rsp_owner_p1 <= rsp_owner_p0;
        end
    end

    // Stage p1: memory read data returns; steer it and keep a held copy
    assign core_rvalid = (rsp_owner_p1 == OWN_CORE);
    assign ldr_rvalid  = (rsp_owner_p1 == OWN_LDR);
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
    assign ldr_rdata   = ldr_rvalid  ? mem_rdata : ldr_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            if (core_rvalid) core_rdata_q <= mem_rdata;
            if (ldr_rvalid)  ldr_rdata_q  <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests with hand-computed grants
// and read data; a negedge monitor pops expected read responses.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
    logic [7:0]  ldr_addr;
    logic [31:0] ldr_wdata, ldr_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  dbg_owner;

    logic [31:0] mem [256];

    typedef struct {
        logic [1:0]  own;
        logic [31:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_owner(dbg_owner)
    );

    // Synchronous single-port memory model, one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the head of the expected-response queue
    always @(negedge clk) begin
        if (rst_n && (core_rvalid || ldr_rvalid)) begin
            chk("rvalid_exclusive", 32'(core_rvalid & ldr_rvalid), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, ldr_rvalid, core_rvalid}, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_owner", {30'd0, ldr_rvalid, core_rvalid}, {30'd0, e.own});
                chk("rsp_data", core_rvalid ? core_rdata : ldr_rdata, e.data);
            end
        end
    end

    task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                        input logic lr, input logic lw, input logic [7:0] la, input logic [31:0] ld,
                        input logic eg_c, input logic eg_l, input logic [31:0] erd, input logic push);
        logic [7:0] e_addr;
        logic       e_we;
        @(negedge clk);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        ldr_req  = lr; ldr_we  = lw; ldr_addr  = la; ldr_wdata  = ld;
        #1;
        e_addr = eg_c ? ca : (eg_l ? la : 8'h00);
        e_we   = eg_c ? cw : (eg_l ? lw : 1'b0);
        chk("core_gnt",   32'(core_gnt),   32'(eg_c));
        chk("ldr_gnt",    32'(ldr_gnt),    32'(eg_l));
        chk("core_stall", 32'(core_stall), 32'(cr && !eg_c));
        chk("dbg_owner",  32'(dbg_owner),  eg_c ? 32'd1 : (eg_l ? 32'd2 : 32'd0));
        chk("mem_en",     32'(mem_en),     32'(eg_c | eg_l));
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("mem_addr",   32'(mem_addr),   32'(e_addr));
        if (push && eg_c && !cw) exp_q.push_back('{2'b01, erd});
        if (push && eg_l && !lw) exp_q.push_back('{2'b10, erd});
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | 32'(i);
        mem[8'h35] = 32'h0d484321;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        ldr_req  = 0; ldr_we  = 0; ldr_addr  = 0; ldr_wdata  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_ldr_rvalid",  32'(ldr_rvalid),  32'd0);
        chk("rst_core_rdata",  core_rdata,       32'd0);
        chk("rst_ldr_rdata",   ldr_rdata,        32'd0);
        chk("rst_mem_en",      32'(mem_en),      32'd0);
        chk("rst_dbg_owner",   32'(dbg_owner),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Core read of 0x35, then hold check on core_rdata
        step(1, 0, 8'h35, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0d484321, 1);
        idle();
        idle();
        chk("core_rdata_hold", core_rdata, 32'h0d484321);
        chk("core_rvalid_once", 32'(core_rvalid), 32'd0);

        // Loader write then read-back of 0x42
        step(0, 0, 8'h00, 32'h0, 1, 1, 8'h42, 32'hdbbdaeea, 0, 1, 32'h0, 1);
        chk("mem_wdata", mem_wdata, 32'hdbbdaeea);
        step(0, 0, 8'h00, 32'h0, 1, 0, 8'h42, 32'h0, 0, 1, 32'hdbbdaeea, 1);
        idle();

        // Continuous conflict: core wins 4 cycles, loader forced on the 5th
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 1, 0, 32'hA5000010, 1);
        step(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 32'hA5000020, 1);
        step(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 1, 0, 32'hA5000010, 1);
        idle();

        // Loader gives up after 2 blocked cycles: counter restarts from zero
        for (int i = 0; i < 2; i++)
            step(1, 0, 8'h11, 32'h0, 1, 0, 8'h21, 32'h0, 1, 0, 32'hA5000011, 1);
        step(1, 0, 8'h11, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'hA5000011, 1);
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'h11, 32'h0, 1, 0, 8'h21, 32'h0, 1, 0, 32'hA5000011, 1);
        step(1, 0, 8'h11, 32'h0, 1, 0, 8'h21, 32'h0, 0, 1, 32'hA5000021, 1);
        idle();

        // Back-to-back: core 0x03 read directly followed by forced loader 0x04
        for (int i = 0; i < 4; i++)
            step(1, 0, 8'h03, 32'h0, 1, 0, 8'h04, 32'h0, 1, 0, 32'hA5000003, 1);
        step(1, 0, 8'h03, 32'h0, 1, 0, 8'h04, 32'h0, 0, 1, 32'hA5000004, 1);
        step(1, 0, 8'h03, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'hA5000003, 1);
        idle();

        // Reset right after a granted read: response dropped, asynchronous clear
        step(1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0, 1, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        core_req = 0; ldr_req = 0;
        #1;
        chk("arst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("arst_ldr_rvalid",  32'(ldr_rvalid),  32'd0);
        chk("arst_core_rdata",  core_rdata,       32'd0);
        chk("arst_ldr_rdata",   ldr_rdata,        32'd0);
        chk("arst_mem_en",      32'(mem_en),      32'd0);
        chk("arst_dbg_owner",   32'(dbg_owner),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the core has priority again and the counter is clear
        for (int i = 0; i < 3; i++)
            step(1, 0, 8'h06, 32'h0, 1, 0, 8'h07, 32'h0, 1, 0, 32'hA5000006, 1);
        idle();
        idle();
        chk("rsp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (8-bit address, 32-bit data) between two requesters: the core MEM stage and the debug/program-loader port.
- The core has default priority. A starvation counter forces a loader grant after MAX_WAIT blocked cycles.
- Drives the stall to the core pipeline whenever the core is denied.
- Sits between the MEM stage, the loader, and the data memory macro in top_multicycle.

Parameters:
- AW, 8, memory address width.
- DW, 32, memory data width.
- MAX_WAIT, 4, number of consecutive blocked loader cycles before the loader is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  core MEM-stage access request.
- core_we  in  1  core write enable (1 = store).
- core_addr  in  AW  core address.
- core_wdata  in  DW  core store data.
- core_gnt  out  1  core access accepted this cycle.
- core_stall  out  1  core_req && !core_gnt; freezes the pipeline.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data.
- ldr_req  in  1  loader access request.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_gnt  out  1  loader access accepted this cycle.
- ldr_rvalid  out  1  loader read data valid.
- ldr_rdata  out  DW  loader read data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid 1 cycle after a read.
- dbg_owner  out  2  00 none, 01 core, 10 loader: owner of the current cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=CORE_PRIO, wait_cnt=0, rsp_owner=none; all rvalid=0; rdata outputs 0.
  - Combinational outputs settle to 0 while no requests are present.
- FSM states:
  - CORE_PRIO: the core wins any conflict.
  - LDR_FORCE: the loader wins any conflict.
- Grant logic (combinational, same cycle):
  - In CORE_PRIO: core_gnt = core_req; ldr_gnt = ldr_req && !core_req.
  - In LDR_FORCE: ldr_gnt = ldr_req; core_gnt = core_req && !ldr_req.
  - Never both granted in one cycle.
- mem_* muxing:
  - mem_* is driven from the granted requester in the same cycle; mem_en = core_gnt | ldr_gnt.
  - mem_addr, mem_wdata and mem_we are 0 when there is no grant.
- Starvation counter (wait_cnt, 4 bits):
  - Increments on each cycle with ldr_req && !ldr_gnt.
  - Clears on ldr_gnt or when ldr_req is low.
- Transitions:
  - CORE_PRIO -> LDR_FORCE on a clock edge where a blocked loader cycle would make wait_cnt reach MAX_WAIT.
  - LDR_FORCE -> CORE_PRIO after the first ldr_gnt, or if ldr_req drops. This makes the force exactly one access.
- Read return:
  - A granted read (gnt && !we) registers rsp_owner.
  - The next cycle, the matching *_rvalid=1 for exactly one cycle, and *_rdata = mem_rdata (registered copy held until the next rvalid for that requester).
  - Writes produce no rvalid.
- Back-to-back: a new grant is allowed every cycle, including a read directly after a read. Read latency is fixed at 1 cycle, so there is no pipeline overlap.
- Requester contract: a requester holds req/we/addr/wdata stable until granted; the arbiter does not buffer requests.
- MAX_WAIT=1: the loader is forced after a single blocked cycle, so core and loader strictly alternate under continuous contention.
- Reset mid-operation: a pending read is dropped, no rvalid is issued, and the FSM and counter return to reset values.

Decomposition:
- Shared package (risc_pkg): AW/DW defaults, owner encoding constants (OWN_NONE, OWN_CORE, OWN_LDR), FSM state enum.
- Optional sub-module arb_starve_cnt: the saturating counter plus the force flag.
- Everything else stays flat.

Test Plan:
- Reset, idle: all outputs 0; then core_req read addr 8'h35 -> core_gnt=1 same cycle, mem_addr=8'h35; next cycle core_rvalid=1, core_rdata=mem_rdata (e.g. 32'h0d484321).
- Loader-only write addr 8'h42, data 32'hdbbdaeea -> ldr_gnt=1, mem_we=1, no rvalid; a read of 8'h42 then returns 32'hdbbdaeea.
- Conflict (core+loader reading continuously, MAX_WAIT=4):
  - Cycles 0-3: core granted, core_stall=0, wait_cnt 1..4.
  - Cycle 4: ldr_gnt=1, core_stall=1.
  - Cycle 5: core granted again.
- ldr_req dropped after 2 blocked cycles -> wait_cnt=0, state stays CORE_PRIO. Re-request then needs the full 4 blocked cycles.
- Back-to-back reads core 8'h03 then loader 8'h04 (forced) -> core_rvalid at t+1 with the 8'h03 data, ldr_rvalid at t+2 with the 8'h04 data; never both valid together.
- rst_n low the cycle after a granted read -> no rvalid; all outputs at reset values; asynchronous assertion visible before the next clock edge.
